packet_read_scheduler: RTL and testbench

//  Round-robin scheduler that shares one MAC TX output between pPORTS per-port packet

---
 rtl/packet_read_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_packet_read_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_read_scheduler.sv
// Round-robin packet read scheduler: shares one TX byte stream between pPORTS packet memories.
// Latency: first TX byte 2 cycles after ogrant rises; TX idle gap 2 cycles (pIFG with ARB_IFG_EN).
// Backpressure: ihold blocks new grants only; a packet in flight always completes. Option macro: ARB_IFG_EN.
module packet_read_scheduler #(
  parameter int pPORTS             = 4,
  parameter int pDATA_WIDTH        = 8,
  parameter int pMAX_PACKET_LENGHT = 1536,
  parameter int pDEPTH_RAM         = 3072,
  parameter int pLEN_W             = 11,
  parameter int pADDR_W            = 12,
  parameter int pIFG               = 12
) (
  input  logic                            iclk,
  input  logic                            i_rst,
  input  logic [pPORTS-1:0]               iempty,
  input  logic [pPORTS*pLEN_W-1:0]        ilen,
  input  logic [pPORTS*pADDR_W-1:0]       iptr,
  input  logic [pPORTS*pDATA_WIDTH-1:0]   ird_data,
  input  logic                            ihold,
  output logic [pADDR_W-1:0]              ord_addr,
  output logic [pPORTS-1:0]               ogrant,
  output logic [pPORTS-1:0]               opop,
  output logic [pDATA_WIDTH-1:0]          otx_d,
  output logic                            otx_dv,
  output logic                            oerr,
  output logic                            obusy
);

  localparam int PW = $clog2(pPORTS);
  // The last GAP cycle also hosts the next grant, so the TX idle gap is GAP_CYC+1 cycles.
`ifdef ARB_IFG_EN
  localparam int GAP_CYC = (pIFG > 1) ? pIFG - 1 : 1;
`else
  localparam int GAP_CYC = 1;
`endif
  localparam int GW = (pIFG > 1) ? $clog2(pIFG) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, GAP} state_t;

  state_t                 r_state;
  logic [PW-1:0]          r_rr_ptr;
  logic [PW-1:0]          r_sel;
  logic [pLEN_W-1:0]      r_len;
  logic [pLEN_W-1:0]      r_cnt;
  logic [pADDR_W-1:0]     r_addr;
  logic [pPORTS-1:0]      r_grant;
  logic [pPORTS-1:0]      r_pop;
  logic                   r_err;
  logic                   r_addr_vld;
  logic                   r_data_vld;
  logic [pDATA_WIDTH-1:0] r_tx_d;
  logic                   r_tx_dv;
  logic [GW-1:0]          r_gap_cnt;

  logic                   w_req_vld;
  logic [PW-1:0]          w_req_idx;
  logic [pLEN_W-1:0]      w_req_len;
  logic [pADDR_W-1:0]     w_req_ptr;
  logic [PW:0]            w_idx_ext;
  logic [pPORTS-1:0]      w_req_onehot;
  logic                   w_len_bad;
  logic                   w_gap_last;
  logic                   w_can_grant;
  logic [PW-1:0]          w_sel_nxt;
  logic [pADDR_W-1:0]     w_addr_inc;
  logic [pDATA_WIDTH-1:0] w_rd_sel;

  // Round-robin search: first non-empty port from the RR pointer upward, with wrap.
  always_comb begin
    w_req_vld = 1'b0;
    w_req_idx = '0;
    w_req_len = '0;
    w_req_ptr = '0;
    w_idx_ext = '0;
    for (int k = 0; k < pPORTS; k++) begin
      w_idx_ext = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_idx_ext >= (PW+1)'(pPORTS)) w_idx_ext = w_idx_ext - (PW+1)'(pPORTS);
      for (int p = 0; p < pPORTS; p++) begin
        if (!w_req_vld && (w_idx_ext == (PW+1)'(p)) && !iempty[p]) begin
          w_req_vld = 1'b1;
          w_req_idx = PW'(p);
          w_req_len = ilen[p*pLEN_W +: pLEN_W];
          w_req_ptr = iptr[p*pADDR_W +: pADDR_W];
        end
      end
    end
  end

  // Read-data mux for the port currently owning the TX pipeline.
  always_comb begin
    w_rd_sel = '0;
    for (int p = 0; p < pPORTS; p++) begin
      if (r_sel == PW'(p)) w_rd_sel = ird_data[p*pDATA_WIDTH +: pDATA_WIDTH];
    end
  end

  assign w_req_onehot = {{(pPORTS-1){1'b0}}, 1'b1} << w_req_idx;
  assign w_len_bad    = (w_req_len == '0) || (32'(w_req_len) > 32'(pMAX_PACKET_LENGHT));
  assign w_gap_last   = (r_gap_cnt == GW'(GAP_CYC - 1));
  assign w_can_grant  = !ihold && w_req_vld &&
                        ((r_state == IDLE) || ((r_state == GAP) && w_gap_last));
  assign w_sel_nxt    = (r_sel == PW'(pPORTS - 1)) ? '0 : r_sel + 1'b1;
  // Stepping the address by one with wrap equals (base + cnt) mod depth since base < depth.
  assign w_addr_inc   = (r_addr == pADDR_W'(pDEPTH_RAM - 1)) ? '0 : r_addr + 1'b1;

  // Scheduler FSM: grant, address sweep, release pulse, inter-frame gap.
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_sel      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_grant    <= '0;
      r_pop      <= '0;
      r_err      <= 1'b0;
      r_addr_vld <= 1'b0;
      r_gap_cnt  <= '0;
    end else begin
      r_pop <= '0;
      r_err <= 1'b0;
      if (w_can_grant) begin
        r_sel   <= w_req_idx;
        r_grant <= w_req_onehot;
        r_len   <= w_req_len;
        r_cnt   <= '0;
        if (w_len_bad) begin
          // Illegal length: release and flag without reading; DRAIN is the release cycle.
          r_pop      <= w_req_onehot;
          r_err      <= 1'b1;
          r_addr_vld <= 1'b0;
          r_state    <= DRAIN;
        end else begin
          r_addr     <= w_req_ptr;
          r_addr_vld <= 1'b1;
          r_state    <= READ;
        end
      end else begin
        case (r_state)
          READ: begin
            if (r_cnt == r_len - 1'b1) begin
              r_pop      <= r_grant;
              r_addr_vld <= 1'b0;
              r_state    <= DRAIN;
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_addr <= w_addr_inc;
            end
          end
          DRAIN: begin
            r_grant   <= '0;
            r_rr_ptr  <= w_sel_nxt;
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end
          GAP: begin
            if (w_gap_last) r_state   <= IDLE;
            else            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // TX pipeline: address cycle -> SRAM data cycle -> registered TX byte.
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      r_data_vld <= 1'b0;
      r_tx_dv    <= 1'b0;
      r_tx_d     <= '0;
    end else begin
      r_data_vld <= r_addr_vld;
      r_tx_dv    <= r_data_vld;
      r_tx_d     <= r_data_vld ? w_rd_sel : '0;
    end
  end

  assign ord_addr = r_addr;
  assign ogrant   = r_grant;
  assign opop     = r_pop;
  assign oerr     = r_err;
  assign otx_d    = r_tx_d;
  assign otx_dv   = r_tx_dv;
  assign obusy    = (r_state != IDLE);

endmodule

// File: tb/tb_packet_read_scheduler.sv
// Directed bench for packet_read_scheduler with port/SRAM model and grant/byte scoreboard.
// Expected grants are queued as packets are offered; bytes are derived from the SRAM model.
// All driving and sampling happens on the falling clock edge.
module tb_packet_read_scheduler;
  localparam int P = 4, DW = 8, LW = 11, AW = 12, DEPTH = 3072, MAXL = 1536;

  logic            clk = 1'b0;
  logic            i_rst;
  logic            ihold;
  logic [P-1:0]    iempty = '1;
  logic [P*LW-1:0] ilen = '0;
  logic [P*AW-1:0] iptr = '0;
  logic [P*DW-1:0] ird_data = '0;
  logic [AW-1:0]   ord_addr;
  logic [P-1:0]    ogrant, opop;
  logic [DW-1:0]   otx_d;
  logic            otx_dv, oerr, obusy;

  always #5 clk = ~clk;

  packet_read_scheduler #(.pPORTS(P), .pDATA_WIDTH(DW), .pMAX_PACKET_LENGHT(MAXL),
                          .pDEPTH_RAM(DEPTH), .pLEN_W(LW), .pADDR_W(AW), .pIFG(12)) dut (
    .iclk(clk), .i_rst(i_rst), .iempty(iempty), .ilen(ilen), .iptr(iptr),
    .ird_data(ird_data), .ihold(ihold), .ord_addr(ord_addr), .ogrant(ogrant),
    .opop(opop), .otx_d(otx_d), .otx_dv(otx_dv), .oerr(oerr), .obusy(obusy));

  typedef struct {int port; int len; bit err;} rec_t;
  rec_t       exp_q[$];
  logic [7:0] byte_q[$];
  int         gap_q[$];
  int         pq[P][$];
  int         pptr[P];
  int         n_checks = 0, n_fail = 0;
  int         pops = 0, bytes = 0, errs = 0;
  bit         mon_en = 1'b0;
  logic [AW-1:0] saved_addr = '0;

  function automatic logic [7:0] mem_byte(int p, int a);
    return 8'((a * 7 + p * 61 + 3) % 256);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(int p, int len);
    rec_t r;
    r.port = p; r.len = len; r.err = (len == 0) || (len > MAXL);
    pq[p].push_back(len);
    exp_q.push_back(r);
  endtask

  task automatic wait_pops(int target, int budget);
    for (int i = 0; i < budget && pops < target; i++) @(negedge clk);
    check("pop_timeout", 32'(pops >= target), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_grant(int budget);
    for (int i = 0; i < budget && ogrant == '0; i++) @(negedge clk);
    check("grant_timeout", 32'(ogrant != '0), 1);
  endtask

  // Port memory model: 1-cycle registered SRAM read, pointer advance and length pop on opop.
  always @(negedge clk) begin
    int l;
    for (int p = 0; p < P; p++) ird_data[p*DW +: DW] = mem_byte(p, int'(saved_addr));
    saved_addr = ord_addr;
    for (int p = 0; p < P; p++) begin
      if (opop[p] && pq[p].size() > 0) begin
        l = pq[p].pop_front();
        if (l > 0 && l <= MAXL) pptr[p] = (pptr[p] + l) % DEPTH;
      end
    end
    for (int p = 0; p < P; p++) begin
      iempty[p]          = (pq[p].size() == 0);
      ilen[p*LW +: LW]   = (pq[p].size() > 0) ? LW'(pq[p][0]) : '0;
      iptr[p*AW +: AW]   = AW'(pptr[p]);
    end
  end

  // Monitor: grant order, address sweep, release timing, TX bytes and gaps.
  int cyc = 0, cur_port = 0, cur_len = 0, cur_ptr = 0, zero_run = 0;
  bit cur_err = 1'b0, in_pkt = 1'b0, prev_pop = 1'b0, prev_dv = 1'b0, seen_dv = 1'b0;
  logic [P-1:0] prev_grant = '0;
  rec_t rec;
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_pop) check("grant_drop", 32'(ogrant), 0);
      if (ogrant != '0 && prev_grant == '0) begin
        check("grant_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          rec = exp_q.pop_front();
          check("grant_port", 32'(ogrant), 32'(1 << rec.port));
          cur_port = rec.port; cur_len = rec.len; cur_err = rec.err;
          cur_ptr = pptr[rec.port]; cyc = 0; in_pkt = 1'b1;
          if (!rec.err)
            for (int i = 0; i < rec.len; i++)
              byte_q.push_back(mem_byte(rec.port, (cur_ptr + i) % DEPTH));
        end
      end else if (ogrant != '0) begin
        check("grant_stable", 32'(ogrant), 32'(prev_grant));
        cyc++;
      end
      if (in_pkt && !cur_err && ogrant != '0 && cyc < cur_len)
        check("rd_addr", 32'(ord_addr), 32'((cur_ptr + cyc) % DEPTH));
      if (opop != '0 || oerr) begin
        check("pop_port", 32'(opop), 32'(1 << cur_port));
        check("pop_time", 32'(cyc), cur_err ? 0 : 32'(cur_len));
        check("err_flag", 32'(oerr), 32'(cur_err));
        pops++;
        if (oerr) errs++;
        in_pkt = 1'b0;
      end
      if (otx_dv) begin
        check("tx_expected", 32'(byte_q.size() != 0), 1);
        if (byte_q.size() != 0) check("tx_byte", 32'(otx_d), 32'(byte_q.pop_front()));
        bytes++;
        if (!prev_dv && seen_dv) gap_q.push_back(zero_run);
        zero_run = 0;
        seen_dv = 1'b1;
      end else begin
        zero_run++;
      end
      prev_dv = otx_dv;
      prev_grant = ogrant;
      prev_pop = (opop != '0);
    end
  end

  int b0, b_r, p0;
  rec_t r0;
  initial begin
    i_rst = 1'b1; ihold = 1'b0;
    for (int p = 0; p < P; p++) pptr[p] = 0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(ogrant), 0);
    check("rst_pop", 32'(opop), 0);
    check("rst_txd", 32'(otx_d), 0);
    check("rst_txdv", 32'(otx_dv), 0);
    check("rst_err", 32'(oerr), 0);
    check("rst_addr", 32'(ord_addr), 0);
    check("rst_busy", 32'(obusy), 0);
    i_rst = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(obusy), 0);

    // Single requester on port 1; ihold raised mid-packet must not truncate it.
    pptr[1] = 100; add_pkt(1, 64);
    wait_grant(20);
    repeat (5) @(negedge clk);
    ihold = 1'b1;
    wait_pops(1, 200);
    check("t1_bytes", 32'(bytes), 64);
    // ihold blocks the next grant until released.
    pptr[3] = 500; add_pkt(3, 8);
    repeat (20) @(negedge clk);
    check("hold_grant", 32'(ogrant), 0);
    check("hold_busy", 32'(obusy), 0);
    check("hold_pops", 32'(pops), 1);
    ihold = 1'b0;
    wait_pops(2, 100);
    check("hold_bytes", 32'(bytes), 72);

    // All four ports busy: rotation 0,1,2,3 with 2-cycle TX gaps.
    gap_q.delete();
    for (int p = 0; p < P; p++) add_pkt(p, 64);
    wait_pops(6, 1000);
    check("rr_bytes", 32'(bytes), 328);
    check("rr_gap_count", 32'(gap_q.size()), 4);
    for (int i = 1; i < 4 && i < gap_q.size(); i++) check("rr_gap_len", 32'(gap_q[i]), 2);

    // Address wrap at the end of the SRAM.
    pptr[2] = 3070; add_pkt(2, 5);
    wait_pops(7, 100);
    check("wrap_bytes", 32'(bytes), 333);

    // Illegal lengths on port 0: released with oerr, nothing transmitted.
    add_pkt(0, 0); add_pkt(0, 1600);
    wait_pops(9, 100);
    check("bad_bytes", 32'(bytes), 333);
    check("bad_errs", 32'(errs), 2);

    // Reset during byte 10 of a port-0 packet with port 1 also waiting.
    b0 = bytes;
    add_pkt(0, 64);
    wait_grant(20);
    add_pkt(1, 16);
    for (int i = 0; i < 200 && bytes < b0 + 10; i++) @(negedge clk);
    check("byte10_timeout", 32'(bytes >= b0 + 10), 1);
    i_rst = 1'b1; p0 = pops;
    @(negedge clk);
    check("mid_rst_grant", 32'(ogrant), 0);
    check("mid_rst_pop", 32'(opop), 0);
    check("mid_rst_txd", 32'(otx_d), 0);
    check("mid_rst_txdv", 32'(otx_dv), 0);
    check("mid_rst_err", 32'(oerr), 0);
    check("mid_rst_addr", 32'(ord_addr), 0);
    check("mid_rst_busy", 32'(obusy), 0);
    check("mid_rst_no_pop", 32'(pops), 32'(p0));
    b_r = bytes;
    byte_q.delete(); in_pkt = 1'b0;
    r0.port = 0; r0.len = 64; r0.err = 1'b0;
    exp_q.push_front(r0);
    i_rst = 1'b0;
    wait_pops(p0 + 2, 400);
    check("post_rst_bytes", 32'(bytes), 32'(b_r + 80));
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    check("bytes_drained", 32'(byte_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
